// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Round-robin writeback arbiter (ALU vs. load) for the register
//               file write port, with a registered write stage and a
//               pending-write scoreboard for decode hazard checks.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [ADDR_WIDTH-1:0]      alu_rd,
    input  logic [DATA_WIDTH-1:0]      alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [ADDR_WIDTH-1:0]      mem_rd,
    input  logic [DATA_WIDTH-1:0]      mem_data,
    input  logic                       claim_valid,
    input  logic [ADDR_WIDTH-1:0]      claim_rd,
    output logic                       rf_we,
    output logic [ADDR_WIDTH-1:0]      rf_waddr,
    output logic [DATA_WIDTH-1:0]      rf_wdata,
    output logic [2**ADDR_WIDTH-1:0]   pending
);

    localparam int         c_NUM_REGS  = 2**ADDR_WIDTH;
    localparam logic [0:0] c_GRANT_ALU = 1'b0;
    localparam logic [0:0] c_GRANT_MEM = 1'b1;

    logic [0:0]            r_last_grant;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [c_NUM_REGS-1:0] r_pending;
    logic [c_NUM_REGS-1:0] w_pending_next;
    logic                  w_alu_ready;
    logic                  w_mem_ready;
    logic                  w_xfer;
    logic [ADDR_WIDTH-1:0] w_rd;
    logic [DATA_WIDTH-1:0] w_data;

    // Ready never depends on r_we: the output stage drains every cycle.
    always_comb begin
        w_alu_ready = 1'b0;
        w_mem_ready = 1'b0;
        if (resetn) begin
            if (alu_valid && mem_valid) begin
                w_alu_ready = (r_last_grant == c_GRANT_MEM);
                w_mem_ready = (r_last_grant == c_GRANT_ALU);
            end else begin
                w_alu_ready = alu_valid;
                w_mem_ready = mem_valid;
            end
        end
    end

    always_comb begin
        w_xfer = w_alu_ready || w_mem_ready;
        w_rd   = w_mem_ready ? mem_rd   : alu_rd;
        w_data = w_mem_ready ? mem_data : alu_data;
    end

    // Claim is applied after the clear so a same-index claim stays outstanding.
    always_comb begin
        w_pending_next = r_pending;
        if (w_xfer && (w_rd != '0)) begin
            w_pending_next[w_rd] = 1'b0;
        end
        if (claim_valid && (claim_rd != '0)) begin
            w_pending_next[claim_rd] = 1'b1;
        end
        w_pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_last_grant <= c_GRANT_MEM;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_pending    <= '0;
        end else begin
            r_we      <= w_xfer && (w_rd != '0);
            r_pending <= w_pending_next;
            if (w_xfer) begin
                r_last_grant <= w_mem_ready ? c_GRANT_MEM : c_GRANT_ALU;
                r_waddr      <= w_rd;
                r_wdata      <= w_data;
            end
        end
    end

    assign alu_ready = w_alu_ready;
    assign mem_ready = w_mem_ready;
    assign rf_we     = r_we;
    assign rf_waddr  = r_waddr;
    assign rf_wdata  = r_wdata;
    assign pending   = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Directed and randomised self-checking bench for
//               rf_write_arbiter against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

    logic        clk;
    logic        resetn;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        claim_valid;
    logic [4:0]  claim_rd;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;

    int n_cmp  = 0;
    int n_fail = 0;

    rf_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .resetn(resetn),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .claim_valid(claim_valid), .claim_rd(claim_rd),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: which requester "should" win given the last winner.
    logic        m_last_mem = 1'b1;
    logic        m_we = 1'b0;
    logic [31:0] m_pend = '0;
    logic        m_alu_acc = 1'b0, m_mem_acc = 1'b0;
    logic        started = 1'b0;
    logic [36:0] exp_q[$];

    function automatic logic [1:0] exp_grant();
        if (!resetn) return 2'b00;
        if (alu_valid && mem_valid) return m_last_mem ? 2'b01 : 2'b10;
        return {mem_valid, alu_valid};
    endfunction

    always @(posedge clk) begin
        logic [1:0]  g;
        logic [4:0]  rd;
        logic [31:0] data;
        g = exp_grant();
        started = 1'b1;
        m_alu_acc = g[0];
        m_mem_acc = g[1];
        if (!resetn) begin
            m_last_mem = 1'b1;
            m_we = 1'b0;
            m_pend = '0;
            exp_q.delete();
        end else begin
            m_we = 1'b0;
            if (g != 2'b00) begin
                rd   = g[0] ? alu_rd   : mem_rd;
                data = g[0] ? alu_data : mem_data;
                m_last_mem = g[1];
                if (rd != 5'd0) begin
                    m_we = 1'b1;
                    exp_q.push_back({rd, data});
                    m_pend[rd] = 1'b0;
                end
            end
            if (claim_valid && claim_rd != 5'd0) m_pend[claim_rd] = 1'b1;
        end
    end

    int alu_wait = 0, mem_wait = 0;

    always @(negedge clk) begin
        logic [1:0]  g;
        logic [36:0] e;
        if (started) begin
            g = exp_grant();
            chk("alu_ready", alu_ready, g[0]);
            chk("mem_ready", mem_ready, g[1]);
            chk("one_ready", alu_ready & mem_ready, 0);
            chk("rf_we", rf_we, m_we);
            if (m_we) begin
                e = exp_q.pop_front();
                chk("rf_waddr", rf_waddr, e[36:32]);
                chk("rf_wdata", rf_wdata, e[31:0]);
            end
            chk("pending", pending, m_pend);
            alu_wait = (resetn && alu_valid && !alu_ready) ? alu_wait + 1 : 0;
            mem_wait = (resetn && mem_valid && !mem_ready) ? mem_wait + 1 : 0;
            chk("alu_wait_bound", alu_wait <= 1, 1);
            chk("mem_wait_bound", mem_wait <= 1, 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0; claim_valid = 1'b0; claim_rd = '0;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h4;
        mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h6;
        step(); step();
        @(negedge clk);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_pending", pending, 0);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);

        // Single ALU write.
        step(); resetn = 1'b1; mem_valid = 1'b0;
        alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_alu_ready", alu_ready, 1);
        chk("t1_mem_ready", mem_ready, 0);
        step(); alu_valid = 1'b0;
        @(negedge clk);
        chk("t1_we", rf_we, 1);
        chk("t1_waddr", rf_waddr, 5);
        chk("t1_wdata", rf_wdata, 32'hDEADBEEF);
        step();
        @(negedge clk);
        chk("t1_we_drop", rf_we, 0);

        // Load to x0: accepted, no write pulse.
        step(); mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h1234;
        @(negedge clk);
        chk("x0_mem_ready", mem_ready, 1);
        step(); mem_valid = 1'b0;
        @(negedge clk);
        chk("x0_no_we", rf_we, 0);
        chk("x0_pending", pending, 0);

        // Sustained tie: ALU, MEM, ALU, MEM.
        step();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("tie_alu_grant", alu_ready, (i % 2 == 0));
            chk("tie_mem_grant", mem_ready, (i % 2 == 1));
            if (i > 0) begin
                chk("tie_we", rf_we, 1);
                chk("tie_waddr", rf_waddr, ((i - 1) % 2 == 0) ? 1 : 2);
            end
            step();
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        chk("tie_we_last", rf_we, 1);
        chk("tie_waddr_last", rf_waddr, 2);
        chk("tie_wdata_last", rf_wdata, 32'h22);
        step();
        @(negedge clk);
        chk("tie_we_end", rf_we, 0);

        // Scoreboard: claim, clear, then simultaneous claim+clear.
        step(); claim_valid = 1'b1; claim_rd = 5'd7;
        step(); claim_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        @(negedge clk);
        chk("sb_claim7", pending, 32'h0000_0080);
        chk("sb_alu_ready", alu_ready, 1);
        step();
        claim_valid = 1'b1; claim_rd = 5'd9;
        alu_rd = 5'd9; alu_data = 32'h99;
        @(negedge clk);
        chk("sb_clear7", pending, 0);
        step(); claim_valid = 1'b0; alu_valid = 1'b0;
        @(negedge clk);
        chk("sb_set_wins", pending, 32'h0000_0200);
        chk("sb_we9", rf_we, 1);
        chk("sb_waddr9", rf_waddr, 9);

        // Reset with a write in flight.
        step(); alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        @(negedge clk);
        chk("mr_alu_ready", alu_ready, 1);
        step(); resetn = 1'b0;
        alu_rd = 5'd1; alu_data = 32'h11; mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h22;
        @(negedge clk);
        chk("mr_rst_alu_ready", alu_ready, 0);
        chk("mr_rst_mem_ready", mem_ready, 0);
        chk("mr_inflight_we", rf_we, 1);
        step();
        @(negedge clk);
        chk("mr_we_dropped", rf_we, 0);
        chk("mr_pending_clr", pending, 0);
        step(); resetn = 1'b1;
        @(negedge clk);
        chk("mr_tie_alu_first", alu_ready, 1);
        chk("mr_tie_mem_wait", mem_ready, 0);
        step(); alu_valid = 1'b0; mem_valid = 1'b0;

        // Random traffic; requests are held until the model says accepted.
        for (int c = 0; c < 2000; c++) begin
            step();
            resetn = ($urandom_range(0, 399) != 0);
            if (!alu_valid || m_alu_acc) begin
                alu_valid = ($urandom_range(0, 9) < 7);
                alu_rd    = 5'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            if (!mem_valid || m_mem_acc) begin
                mem_valid = ($urandom_range(0, 9) < 7);
                mem_rd    = 5'($urandom_range(0, 31));
                mem_data  = $urandom;
            end
            claim_valid = ($urandom_range(0, 9) < 3);
            claim_rd    = 5'($urandom_range(0, 31));
        end
        step(); resetn = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0; claim_valid = 1'b0;
        repeat (3) step();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Sequencer for the 32x32 register file's single write port. It arbitrates between two writeback requesters, the ALU/execute result and the memory-load result, using round-robin valid/ready handshakes, and drives the file's write enable, destination address and write data from a registered stage. It also keeps a pending-write scoreboard that decode uses for hazard checks.

## Interface
Parameters:
- DATA_WIDTH, 32, width of write data
- ADDR_WIDTH, 5, register address width; the file holds 2**ADDR_WIDTH entries

Ports:
- clk  in  1  rising-edge clock; the only clock
- resetn  in  1  reset, synchronous, active-low
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  ADDR_WIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- mem_valid  in  1  load result offered
- mem_ready  out  1  load result accepted this cycle
- mem_rd  in  ADDR_WIDTH  load destination register
- mem_data  in  DATA_WIDTH  load result
- claim_valid  in  1  decode issues an instruction that will write claim_rd
- claim_rd  in  ADDR_WIDTH  claimed destination register
- rf_we  out  1  to register file regWrite
- rf_waddr  out  ADDR_WIDTH  to register file destination address
- rf_wdata  out  DATA_WIDTH  to register file dataIn
- pending  out  2**ADDR_WIDTH  bit i set means register i has an outstanding write

## Operation
- A transfer occurs when valid and ready are both high in the same cycle. At most one ready is high per cycle.
- Ready rules (combinational from valids and pointer):
  - Only one valid high: that requester gets ready.
  - Both valid high: the requester not granted most recently gets ready.
  - Neither valid: both ready low and the pointer is unchanged.
- A last_grant pointer updates on every transfer. At reset it points to MEM, so ALU wins the first tie.
- The accepted rd and data are captured into the output register. rf_we is set to 1 only if the captured rd is nonzero. A write to x0 is accepted but produces no rf_we pulse.
- The output stage always frees up the next cycle, so ready does not depend on rf_we. Sustained throughput is one write per cycle.
- Scoreboard, updated at the clock edge:
  - Set: claim_valid with claim_rd nonzero sets pending[claim_rd].
  - Clear: a transfer with rd nonzero clears pending[rd].
  - Set and clear on the same index in the same cycle: set wins, because the newer claim is still outstanding.
  - pending[0] is always 0.
  - A transfer to a register whose pending bit is 0 is legal and leaves the bit 0.
- Requesters must hold valid, rd and data stable until accepted. The block does not check this.

## Timing
- Reset (resetn low at a rising edge) drives: rf_we=0, rf_waddr=0, rf_wdata=0, pending=0, last_grant=MEM.
- alu_ready and mem_ready are forced to 0 in any cycle where resetn is low.
- Reset mid-operation: a captured but not yet written result is dropped (rf_we is 0 next cycle), and all pending bits clear.
- Latency: a transfer at edge N makes rf_we/rf_waddr/rf_wdata valid during cycle N+1. The register file commits at edge N+1, so a read of that register sees the new value in cycle N+2.
- pending is registered:
  - a claim at edge N is visible from cycle N+1;
  - the clear from a transfer at edge N is visible from cycle N+1, one cycle before the file holds the data. Decode must treat pending=0 with a write in flight as forwarding-eligible, or stall one more cycle.
- rf_we is a single-cycle pulse per transfer. With back-to-back transfers it stays high continuously, with a new address and data each cycle.

## Test plan
- Reset, then alu_valid=1 with rd=5, data=0xDEADBEEF, mem_valid=0:
  - alu_ready=1 in the same cycle;
  - next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF;
  - the cycle after, rf_we=0.
- Both valid held for 4 cycles (ALU rd=1, MEM rd=2):
  - grants go ALU, MEM, ALU, MEM;
  - rf_waddr sequence is 1,2,1,2 with rf_we high for 4 consecutive cycles.
- mem_valid with rd=0, data=0x1234:
  - mem_ready=1;
  - rf_we stays 0 the next cycle;
  - pending is unchanged.
- Scoreboard sequence:
  - claim rd=7 -> pending[7]=1 the next cycle;
  - ALU transfer rd=7 -> pending[7]=0 the next cycle.
  - Then claim rd=9 and transfer rd=9 in the same cycle -> pending[9]=1 afterwards.
- Transfer rd=3 accepted, then resetn=0 in the following cycle:
  - rf_we=0 in the cycle after reset;
  - pending=0 and both readies 0 while resetn is low;
  - after release, a tie grants ALU first.
- A random 2000-cycle run with a reference model checks:
  - at most one ready per cycle;
  - every nonzero-rd transfer appears on the write port exactly once, in order;
  - no requester waits more than 1 cycle under a continuous tie.
